load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 25 ++
 rtl/load_store_unit_load_extend.sv | 21 ++
 rtl/load_store_unit.sv | 134 +++++++++++++
 tb/tb_load_store_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the byte-serial load/store unit.
// Access-size encodings, FSM states and the last-byte index helper.
package load_store_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DRAIN,
        DONE
    } state_t;

    // Index of the final byte of an access (N-1).
    function automatic logic [1:0] last_idx(input logic [1:0] size);
        case (size)
            SZ_HALF: last_idx = 2'd1;
            SZ_WORD: last_idx = 2'd3;
            default: last_idx = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Sign/zero extension of an assembled load word.
// Bytes above the access width are replaced by the fill value.
module load_extend
    import load_store_unit_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] ext
);

    always_comb begin
        ext = raw;
        case (size)
            SZ_BYTE: ext = {{24{sign_ext & raw[7]}}, raw[7:0]};
            SZ_HALF: ext = {{16{sign_ext & raw[15]}}, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit driving a byte-wide synchronous data memory.
// Accesses are serialised one byte per cycle, little-endian.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              IsMemRead,
    input  logic              IsMemWrite,
    input  logic [1:0]        size_i,
    input  logic              sign_ext_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       data_i,
    output logic [31:0]       data_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [7:0]        mem_wdata_o,
    input  logic [7:0]        mem_rdata_i
);

    state_t            state_q;
    state_t            state_d;
    logic [1:0]        k_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       raw_q;
    logic [1:0]        size_q;
    logic              sign_q;
    logic              load_q;
    logic              err_q;
    logic              accept;
    logic              bad_req;
    logic              no_op;
    logic              last;
    logic [31:0]       assembled;
    logic [31:0]       ext;
    logic              unused_addr;

    assign unused_addr = ^addr_i[31:ADDR_W];

    assign accept  = req_valid_i && (state_q == IDLE);
    assign no_op   = !IsMemRead && !IsMemWrite;
    assign bad_req = (size_i == 2'b11)
                   || (IsMemRead && IsMemWrite)
                   || (size_i == SZ_HALF && addr_i[0])
                   || (size_i == SZ_WORD && addr_i[1:0] != 2'b00);
    assign last    = (k_q == last_idx(size_q));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i)
                    state_d = (bad_req || no_op) ? DONE : ACCESS;
            end
            ACCESS: begin
                if (last) state_d = load_q ? DRAIN : DONE;
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = (state_q == IDLE);
        done_o      = (state_q == DONE);
        err_o       = (state_q == DONE) && err_q;
        mem_we_o    = (state_q == ACCESS) && !load_q;
        mem_addr_o  = '0;
        mem_wdata_o = 8'h00;
        if (state_q == ACCESS)
            mem_addr_o = addr_q + ADDR_W'(k_q);
        if (mem_we_o)
            mem_wdata_o = wdata_q[{k_q, 3'b000} +: 8];
    end

    // Final byte arrives during DRAIN and is merged straight into the result.
    always_comb begin
        assembled = raw_q;
        assembled[{last_idx(size_q), 3'b000} +: 8] = mem_rdata_i;
    end

    load_extend u_extend (
        .raw      (assembled),
        .size     (size_q),
        .sign_ext (sign_q),
        .ext      (ext)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            k_q     <= 2'd0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            raw_q   <= 32'h0;
            size_q  <= SZ_BYTE;
            sign_q  <= 1'b0;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
            data_o  <= 32'h0;
        end else begin
            if (accept) begin
                k_q     <= 2'd0;
                addr_q  <= addr_i[ADDR_W-1:0];
                wdata_q <= data_i;
                raw_q   <= 32'h0;
                size_q  <= size_i;
                sign_q  <= sign_ext_i;
                load_q  <= IsMemRead;
                err_q   <= bad_req;
            end
            if (state_q == ACCESS) begin
                k_q <= last ? 2'd0 : k_q + 2'd1;
                if (load_q && k_q != 2'd0)
                    raw_q[{k_q - 2'd1, 3'b000} +: 8] <= mem_rdata_i;
            end
            if (state_q == DRAIN)
                data_o <= ext;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural byte memory.
// Vector table plus a reset-abort sequence.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        IsMemRead;
    logic        IsMemWrite;
    logic [1:0]  size_i;
    logic        sign_ext_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        done_o;
    logic        err_o;
    logic [4:0]  mem_addr_o;
    logic        mem_we_o;
    logic [7:0]  mem_wdata_o;
    logic [7:0]  mem_rdata_i;

    logic [7:0]  mem [32] = '{default: 8'h00};

    int applied = 0;
    int errs = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(5)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .IsMemRead   (IsMemRead),
        .IsMemWrite  (IsMemWrite),
        .size_i      (size_i),
        .sign_ext_i  (sign_ext_i),
        .addr_i      (addr_i),
        .data_i      (data_i),
        .data_o      (data_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .mem_addr_o  (mem_addr_o),
        .mem_we_o    (mem_we_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i)
    );

    always @(posedge clk) begin
        if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
        mem_rdata_i <= mem[mem_addr_o];
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          done_cyc;
        logic        err;
        int          we_cnt;
        logic [31:0] data;
    } vec_t;

    vec_t vt [17];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          dc;
        int          wc;
        int          bad;
        logic        e;
        logic [31:0] dv;
        dc = -1;
        wc = 0;
        bad = 0;
        e = 1'bx;
        dv = 'x;
        @(negedge clk);
        chk($sformatf("v%0d_idle_ready", idx), {31'b0, req_ready_o}, 32'd1);
        chk($sformatf("v%0d_idle_addr", idx),
            {26'b0, mem_we_o, mem_addr_o}, 32'd0);
        IsMemRead   = v.rd;
        IsMemWrite  = v.wr;
        size_i      = v.size;
        sign_ext_i  = v.sext;
        addr_i      = v.addr;
        data_i      = v.wdata;
        req_valid_i = 1'b1;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            if (mem_we_o) begin
                if (wc > 3 || mem_addr_o != 5'(v.addr + 32'(wc))
                    || mem_wdata_o != v.wdata[8*wc +: 8])
                    bad++;
                wc++;
            end
            if (done_o) begin
                dc = j;
                e  = err_o;
                dv = data_o;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk($sformatf("v%0d_done_cycle", idx), dc, v.done_cyc);
        chk($sformatf("v%0d_err", idx), {31'b0, e}, {31'b0, v.err});
        chk($sformatf("v%0d_data", idx), dv, v.data);
        chk($sformatf("v%0d_we_count", idx), wc, v.we_cnt);
        chk($sformatf("v%0d_write_seq", idx), bad, 0);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_done_drop", idx),
            {30'b0, done_o, req_ready_o}, 32'd1);
    endtask

    initial begin
        int d;
        vt[0]  = '{0, 1, 2'b10, 0, 32'h04, 32'h11223344, 5, 0, 4, 32'h00000000};
        vt[1]  = '{1, 0, 2'b10, 0, 32'h04, 32'h0, 6, 0, 0, 32'h11223344};
        vt[2]  = '{0, 1, 2'b00, 0, 32'h09, 32'h00000080, 2, 0, 1, 32'h11223344};
        vt[3]  = '{1, 0, 2'b00, 1, 32'h09, 32'h0, 3, 0, 0, 32'hFFFFFF80};
        vt[4]  = '{1, 0, 2'b00, 0, 32'h09, 32'h0, 3, 0, 0, 32'h00000080};
        vt[5]  = '{0, 1, 2'b01, 0, 32'h03, 32'h0000DEAD, 1, 1, 0, 32'h00000080};
        vt[6]  = '{0, 1, 2'b10, 0, 32'h1C, 32'hAABBCCDD, 5, 0, 4, 32'h00000080};
        vt[7]  = '{0, 1, 2'b01, 0, 32'h3E, 32'h00005566, 3, 0, 2, 32'h00000080};
        vt[8]  = '{1, 0, 2'b10, 0, 32'h1C, 32'h0, 6, 0, 0, 32'h5566CCDD};
        vt[9]  = '{1, 0, 2'b01, 1, 32'h1C, 32'h0, 4, 0, 0, 32'hFFFFCCDD};
        vt[10] = '{1, 0, 2'b10, 0, 32'h02, 32'h0, 1, 1, 0, 32'hFFFFCCDD};
        vt[11] = '{1, 0, 2'b11, 0, 32'h00, 32'h0, 1, 1, 0, 32'hFFFFCCDD};
        vt[12] = '{1, 1, 2'b00, 0, 32'h00, 32'h5A, 1, 1, 0, 32'hFFFFCCDD};
        vt[13] = '{0, 0, 2'b10, 0, 32'h00, 32'h0, 1, 0, 0, 32'hFFFFCCDD};
        vt[14] = '{1, 0, 2'b00, 1, 32'h05, 32'h0, 3, 0, 0, 32'h00000033};
        vt[15] = '{1, 0, 2'b01, 0, 32'h06, 32'h0, 4, 0, 0, 32'h00001122};
        vt[16] = '{1, 0, 2'b10, 1, 32'hFFFFFFE4, 32'h0, 6, 0, 0, 32'h11223344};

        rst_i       = 1'b0;
        req_valid_i = 1'b0;
        IsMemRead   = 1'b0;
        IsMemWrite  = 1'b0;
        size_i      = 2'b00;
        sign_ext_i  = 1'b0;
        addr_i      = 32'h0;
        data_i      = 32'h0;

        #3;
        chk("rst_data", data_o, 32'h0);
        chk("rst_flags", {28'b0, done_o, err_o, mem_we_o, req_ready_o}, 32'd1);
        chk("rst_mem_if", {19'b0, mem_addr_o, mem_wdata_o}, 32'h0);
        #19 rst_i = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {31'b0, req_ready_o}, 32'd1);

        for (int i = 0; i < 17; i++) run_vec(i, vt[i]);

        chk("mem_4_7", {mem[7], mem[6], mem[5], mem[4]}, 32'h11223344);
        chk("mem_28_31", {mem[31], mem[30], mem[29], mem[28]}, 32'h5566CCDD);
        chk("mem_3_untouched", {24'b0, mem[3]}, 32'h0);
        chk("mem_9", {24'b0, mem[9]}, 32'h80);

        // Reset lands just after the second byte of a word store commits.
        @(negedge clk);
        IsMemRead   = 1'b0;
        IsMemWrite  = 1'b1;
        size_i      = 2'b10;
        addr_i      = 32'h0;
        data_i      = 32'hCAFEBABE;
        req_valid_i = 1'b1;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        chk("abort_first_we", {26'b0, mem_we_o, mem_addr_o}, 32'h20);
        @(posedge clk);
        @(posedge clk);
        #1 rst_i = 1'b0;
        #1;
        chk("abort_we_drop", {31'b0, mem_we_o}, 32'd0);
        chk("abort_if_idle", {19'b0, mem_addr_o, mem_wdata_o}, 32'h0);
        chk("abort_no_done", {30'b0, done_o, err_o}, 32'd0);
        @(posedge clk);
        #2 rst_i = 1'b1;
        @(negedge clk);
        chk("abort_ready", {31'b0, req_ready_o}, 32'd1);
        d = 0;
        for (int j = 0; j < 6; j++) begin
            if (done_o || mem_we_o) d++;
            @(negedge clk);
        end
        chk("abort_quiet", d, 0);
        chk("abort_mem", {mem[3], mem[2], mem[1], mem[0]}, 32'h0000BABE);

        $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
        $finish;
    end

endmodule
